// File: rtl/i2s_receiver_pkg.sv
// Shared definitions for the I2S receiver: sample-size codes, FSM state type
// and the decode from size code to word width in bits.
package i2s_receiver_pkg;

    localparam logic [3:0] SIZE_8  = 4'd0;
    localparam logic [3:0] SIZE_12 = 4'd1;
    localparam logic [3:0] SIZE_16 = 4'd3;
    localparam logic [3:0] SIZE_24 = 4'd4;
    localparam logic [3:0] SIZE_32 = 4'd5;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_e;

    // Unlisted codes fall back to 16-bit words.
    function automatic logic [CNT_W-1:0] size_to_width(input logic [3:0] code);
        logic [CNT_W-1:0] width;
        case (code)
            SIZE_8:  width = 6'd8;
            SIZE_12: width = 6'd12;
            SIZE_16: width = 6'd16;
            SIZE_24: width = 6'd24;
            SIZE_32: width = 6'd32;
            default: width = 6'd16;
        endcase
        return width;
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the asynchronous I2S lines into the clk domain through 2-FF
// synchronizers and produces a one-clk strobe on each bit-clock rising edge.
module i2s_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk_in,
    input  logic ws_in,
    input  logic sd_in,
    output logic sclk_rise,
    output logic ws_sync,
    output logic sd_sync
);

    logic [1:0] sclk_ff_q, sclk_ff_d;
    logic [1:0] ws_ff_q, ws_ff_d;
    logic [1:0] sd_ff_q, sd_ff_d;
    logic       sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_ff_d   = {sclk_ff_q[0], sclk_in};
        ws_ff_d     = {ws_ff_q[0], ws_in};
        sd_ff_d     = {sd_ff_q[0], sd_in};
        sclk_prev_d = sclk_ff_q[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_ff_q   <= '0;
            ws_ff_q     <= '0;
            sd_ff_q     <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_ff_q   <= sclk_ff_d;
            ws_ff_q     <= ws_ff_d;
            sd_ff_q     <= sd_ff_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // ws and sd leave the synchronizer aligned with sclk, so they are valid on the strobe.
    assign sclk_rise = sclk_ff_q[1] & ~sclk_prev_q;
    assign ws_sync   = ws_ff_q[1];
    assign sd_sync   = sd_ff_q[1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: locks onto the first left channel, shifts in left/right words
// of a selectable width and hands complete stereo frames to a ready/valid consumer.
module i2s_receiver
    import i2s_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              ws_in,
    input  logic              sd_in,
    input  logic [3:0]        sample_size,
    input  logic              sample_ready,
    output logic [WORD_W-1:0] sample_left,
    output logic [WORD_W-1:0] sample_right,
    output logic              sample_valid,
    output logic              busy_left,
    output logic              busy_right,
    output logic              overrun,
    output logic              short_word
);

    logic sclk_rise, ws_sync, sd_sync;

    i2s_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk_in   (sclk_in),
        .ws_in     (ws_in),
        .sd_in     (sd_in),
        .sclk_rise (sclk_rise),
        .ws_sync   (ws_sync),
        .sd_sync   (sd_sync)
    );

    rx_state_e         state_q, state_d;
    logic              ws_prev_q, ws_prev_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              done_q, done_d;
    logic [WORD_W-1:0] left_word_q, left_word_d;
    logic              have_left_q, have_left_d;
    logic [WORD_W-1:0] sample_left_q, sample_left_d;
    logic [WORD_W-1:0] sample_right_q, sample_right_d;
    logic              valid_q, valid_d;
    logic              busy_left_q, busy_left_d;
    logic              busy_right_q, busy_right_d;
    logic              overrun_q, overrun_d;
    logic              short_word_q, short_word_d;

    logic [CNT_W-1:0]  count_n;
    logic [WORD_W-1:0] shift_n;
    logic [WORD_W-1:0] word_aligned;
    logic              took_bit, ws_flip, sync_exit, word_end, commit;

    always_comb begin
        state_d        = state_q;
        ws_prev_d      = ws_prev_q;
        width_d        = width_q;
        count_d        = count_q;
        shift_d        = shift_q;
        done_d         = done_q;
        left_word_d    = left_word_q;
        have_left_d    = have_left_q;
        sample_left_d  = sample_left_q;
        sample_right_d = sample_right_q;
        valid_d        = valid_q;
        busy_left_d    = busy_left_q;
        busy_right_d   = busy_right_q;
        overrun_d      = 1'b0;
        short_word_d   = 1'b0;
        count_n        = count_q;
        shift_n        = shift_q;
        took_bit       = 1'b0;
        ws_flip        = 1'b0;
        sync_exit      = 1'b0;
        word_end       = 1'b0;
        commit         = 1'b0;

        // The bit sampled with a ws change is still the LSB slot of the outgoing word.
        if (sclk_rise) begin
            ws_prev_d = ws_sync;
            ws_flip   = ((state_q == ST_LEFT) && ws_sync) || ((state_q == ST_RIGHT) && !ws_sync);
            sync_exit = (state_q == ST_SYNC) && ws_prev_q && !ws_sync;
            if ((state_q != ST_SYNC) && !done_q) begin
                if (count_q < width_q) begin
                    shift_n  = {shift_q[WORD_W-2:0], sd_sync};
                    count_n  = count_q + 6'd1;
                    took_bit = 1'b1;
                end
                word_end = ws_flip || (count_n == width_q);
            end
        end

        word_aligned = shift_n << (width_q - count_n);

        if (word_end) begin
            done_d       = 1'b1;
            short_word_d = ws_flip && (count_n < width_q);
            if (state_q == ST_LEFT) begin
                busy_left_d = 1'b0;
                left_word_d = word_aligned;
                have_left_d = 1'b1;
            end else begin
                busy_right_d = 1'b0;
                commit       = have_left_q;
                have_left_d  = 1'b0;
            end
        end else if (took_bit) begin
            busy_left_d  = (state_q == ST_LEFT);
            busy_right_d = (state_q == ST_RIGHT);
        end

        if (ws_flip || sync_exit) begin
            state_d = (state_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
            width_d = size_to_width(sample_size);
            count_d = '0;
            shift_d = '0;
            done_d  = 1'b0;
        end else begin
            count_d = count_n;
            shift_d = shift_n;
        end

        // An unaccepted frame has priority; a simultaneous accept frees the slot.
        if (commit) begin
            if (valid_q && !sample_ready) begin
                overrun_d = 1'b1;
            end else begin
                sample_left_d  = left_word_q;
                sample_right_d = word_aligned;
                valid_d        = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_SYNC;
            ws_prev_q      <= 1'b0;
            width_q        <= '0;
            count_q        <= '0;
            shift_q        <= '0;
            done_q         <= 1'b0;
            left_word_q    <= '0;
            have_left_q    <= 1'b0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            valid_q        <= 1'b0;
            busy_left_q    <= 1'b0;
            busy_right_q   <= 1'b0;
            overrun_q      <= 1'b0;
            short_word_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            ws_prev_q      <= ws_prev_d;
            width_q        <= width_d;
            count_q        <= count_d;
            shift_q        <= shift_d;
            done_q         <= done_d;
            left_word_q    <= left_word_d;
            have_left_q    <= have_left_d;
            sample_left_q  <= sample_left_d;
            sample_right_q <= sample_right_d;
            valid_q        <= valid_d;
            busy_left_q    <= busy_left_d;
            busy_right_q   <= busy_right_d;
            overrun_q      <= overrun_d;
            short_word_q   <= short_word_d;
        end
    end

    assign sample_left  = sample_left_q;
    assign sample_right = sample_right_q;
    assign sample_valid = valid_q;
    assign busy_left    = busy_left_q;
    assign busy_right   = busy_right_q;
    assign overrun      = overrun_q;
    assign short_word   = short_word_q;

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter: none; all sizing is fixed in this specification.
REQ-002 clk  input  1  system clock; sole clock domain; all outputs are registered on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 sclk_in  input  1  I2S bit clock, asynchronous to clk; frequency SHALL be at most clk/4.
REQ-005 ws_in  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-006 sd_in  input  1  I2S serial data, asynchronous.
REQ-007 sample_size  input  4  word width code: 0=8, 1=12, 3=16, 4=24, 5=32 bits; any other code = 16.
REQ-008 sample_ready  input  1  consumer accepts the pending frame.
REQ-009 sample_left  output  32  last committed left word, right-justified, zero-extended.
REQ-010 sample_right  output  32  last committed right word, right-justified, zero-extended.
REQ-011 sample_valid  output  1  a committed frame is pending; held until accepted.
REQ-012 busy_left / busy_right  output  1 each  high while the corresponding word is being shifted in.
REQ-013 overrun  output  1  one-clk pulse when a frame is dropped.
REQ-014 short_word  output  1  one-clk pulse when a word ends before sample_size bits arrive.

Function
REQ-015 sclk_in, ws_in and sd_in SHALL each pass a 2-FF synchronizer.
REQ-016 An internal strobe SHALL fire for one clk on each synchronized sclk rising edge; ws and sd are sampled only on that strobe.
REQ-017 FSM states: SYNC, LEFT, RIGHT.
REQ-018 SYNC is entered at reset; SYNC -> LEFT on the first sampled ws 1->0 transition; all data before it is discarded.
REQ-019 LEFT -> RIGHT on sampled ws 0->1; RIGHT -> LEFT on sampled ws 1->0.
REQ-020 Per I2S, the MSB of a word SHALL be sampled on the strobe one strobe after the ws transition is sampled; bits are received MSB first.
REQ-021 sample_size SHALL be latched at each ws transition and held for that word; mid-word changes have no effect.
REQ-022 The word bit counter SHALL count received bits; bits beyond the latched width are ignored.
REQ-023 A word completes when width bits are received, or at the next ws transition, whichever comes first.
REQ-024 On a short word (ws transition before width bits), the received bits SHALL be MSB-aligned within the width, lower bits zero, and short_word SHALL pulse.
REQ-025 Frame commit occurs when a right word completes after a left word in the same frame; commit updates sample_left/sample_right together and sets sample_valid the next clk.
REQ-026 sample_valid clears on the clk after sample_valid && sample_ready.
REQ-027 If a commit occurs while sample_valid && !sample_ready, outputs keep the old frame, the new frame is dropped, and overrun pulses.
REQ-028 If a commit coincides with an acceptance, the new frame is loaded and sample_valid stays high.
REQ-029 busy_left is high from the left MSB strobe to left word completion; busy_right likewise; the two are never high together.

Reset
REQ-030 While rst=0: state=SYNC, all outputs 0, shift registers, counters and synchronizers cleared; assertion mid-word discards the partial frame.
REQ-031 After rst release, no commit occurs before a full SYNC -> LEFT -> RIGHT sequence.

Structure
REQ-032 Shared package holds the sample_size codes (shared with shift_register), the FSM state type and the width-decode function.
REQ-033 A single sub-module, i2s_rx_sync, implements the 2-FF synchronizers and the sclk rising-edge strobe.

Verification
REQ-034 Size 16, left=16'hA5C3, right=16'h1234, sample_ready=1 -> sample_left=32'h0000A5C3, sample_right=32'h00001234, one valid pulse per frame.
REQ-035 Size 24 within 32-bit slots, left=24'h800001 -> sample_left=32'h00800001; the 8 trailing bits are ignored; no short_word pulse.
REQ-036 Size 32 with ws toggling after 20 bits, bits=20'hFFFFF -> word=32'hFFFFF000; short_word pulses once.
REQ-037 sample_ready=0 for two frames -> first frame held, overrun pulses once; after ready, the first frame is read.
REQ-038 Start stimulus mid right-word -> no commit until after the first ws 1->0; rst pulse mid left word -> outputs 0, FSM returns to SYNC.
